// File: rtl/cpu5_instenc.sv
// RV32I instruction encoder (LW/SW/ADDI/ADD/SUB/BEQ/BNE/JALR) feeding a small output FIFO.
// Optional immediate-range error tagging is enabled by defining CPU5_INSTENC_IMMCHK_EN.
module cpu5_instenc #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_kind,
  input  logic [4:0]                in_rd,
  input  logic [4:0]                in_rs1,
  input  logic [4:0]                in_rs2,
  input  logic [31:0]               in_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_inst,
  output logic                      out_err,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_W-1:0]          enc_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [2:0] {
    K_LW, K_SW, K_ADDI, K_ADD, K_SUB, K_BEQ, K_BNE, K_JALR
  } kind_e;

  kind_e       kind;
  logic [31:0] enc;

  assign kind = kind_e'(in_kind);

  always_comb begin
    enc = '0;
    case (kind)
      K_LW:   enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      K_SW:   enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      K_ADDI: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      K_ADD:  enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      K_SUB:  enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      K_BEQ:  enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], 7'b1100011};
      K_BNE:  enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                     in_imm[4:1], in_imm[11], 7'b1100011};
      K_JALR: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      default: enc = '0;
    endcase
  end

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  // Full refuses a push even when the head pops in the same cycle.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      enc_count <= '0;
    end else begin
      if (push) enc_count <= enc_count + CNT_W'(1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= enc;
  end

  assign out_inst = out_valid ? mem[rd_ptr] : '0;

`ifdef CPU5_INSTENC_IMMCHK_EN
  logic              enc_err;
  logic signed [31:0] simm;
  logic              err_mem [DEPTH];

  assign simm = $signed(in_imm);

  // Branch offsets must also be halfword aligned.
  always_comb begin
    enc_err = 1'b0;
    case (kind)
      K_LW, K_SW, K_ADDI, K_JALR:
        enc_err = (simm < -32'sd2048) || (simm > 32'sd2047);
      K_BEQ, K_BNE:
        enc_err = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
      default: enc_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !reset) err_mem[wr_ptr] <= enc_err;
  end

  assign out_err = out_valid & err_mem[rd_ptr];
`else
  assign out_err = 1'b0;
`endif

endmodule
